// File: rtl/booth_product_accumulator.sv
// Burst accumulator behind the Booth multiplier. It sums signed 2N-bit
// products into a saturating ACC_W-bit total. The burst total, beat count
// and overflow flag are presented on a valid/ready output.
//
// state | meaning
// ACCUM | collecting product beats, in_ready high
// DONE  | burst closed; result loads, then waits for out_ready
module booth_product_accumulator #(
    parameter int N       = 32,
    parameter int ACC_W   = 72,
    parameter int MAX_LEN = 16,
    localparam int CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2*N-1:0]   in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [CW-1:0]    count;
    logic             overflow;

    logic             beat;
    logic [ACC_W:0]   sum_wide;
    logic             ovf_now;
    logic [ACC_W-1:0] sat_sum;
    logic [CW-1:0]    count_inc;
    logic             close;

    // in_ready is a pure state decode, so out_ready has no path to it.
    assign in_ready = (state == ACCUM);
    assign beat     = in_valid && in_ready;

    // Add one guard bit and saturate. The guard bit differs from the sign
    // bit exactly when the true sum leaves the signed ACC_W range.
    always_comb begin
        sum_wide  = {acc[ACC_W-1], acc}
                  + {{(ACC_W + 1 - 2*N){in_product[2*N-1]}}, in_product};
        ovf_now   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
        sat_sum   = sum_wide[ACC_W-1:0];
        if (ovf_now) begin
            if (sum_wide[ACC_W]) begin
                sat_sum = {1'b1, {(ACC_W-1){1'b0}}};
            end else begin
                sat_sum = {1'b0, {(ACC_W-1){1'b1}}};
            end
        end
        count_inc = count + CW'(1);
        close     = in_last || (count_inc == CW'(MAX_LEN));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: close on the last (or MAX_LEN-th) beat; reopen after the result is taken.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: begin
                if (beat && close) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_valid && out_ready) begin
                    state_next = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    // Accumulate beats. In DONE, load the result once and clear when it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            count        <= '0;
            overflow     <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat) begin
                        acc      <= sat_sum;
                        count    <= count_inc;
                        overflow <= overflow | ovf_now;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid    <= 1'b1;
                        out_sum      <= acc;
                        out_count    <= count;
                        out_overflow <= overflow;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        acc       <= '0;
                        count     <= '0;
                        overflow  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
